// File: rtl/axi4_wr_burst_master.sv
// Single-command AXI4 write master: splits 4 KB crossings into two INCR bursts.
// Optional BRESP watchdog enabled by defining AXI4_WR_BURST_WDOG_EN.
module axi4_wr_burst_master #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 128,
   parameter int ID_W = 2,
   parameter logic [3:0] AWCACHE_VAL = 4'b0011
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [7:0]          cmd_len,
   input  logic [ID_W-1:0]     cmd_id,
   input  logic                wd_valid,
   output logic                wd_ready,
   input  logic [DATA_W-1:0]   wd_data,
   input  logic [DATA_W/8-1:0] wd_strb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [ID_W-1:0]     rsp_id,
   output logic [1:0]          rsp_resp,
   output logic [ADDR_W-1:0]   awaddr,
   output logic [7:0]          awlen,
   output logic [ID_W-1:0]     awid,
   output logic [2:0]          awsize,
   output logic [1:0]          awburst,
   output logic [3:0]          awcache,
   output logic                awlock,
   output logic [2:0]          awprot,
   output logic [3:0]          awqos,
   output logic [3:0]          awregion,
   output logic                awvalid,
   input  logic                awready,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wlast,
   output logic                wvalid,
   input  logic                wready,
   input  logic [ID_W-1:0]     bid,
   input  logic [1:0]          bresp,
   input  logic                bvalid,
`ifdef AXI4_WR_BURST_WDOG_EN
   output logic                wdog_err,
`endif
   output logic                bready
);

   localparam int PW = ADDR_W - 12;

   typedef enum logic [1:0] {S_IDLE, S_BURST, S_BRESP, S_RSP} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   awaddr_q, awaddr_d, b1_addr_q, b1_addr_d;
   logic [7:0]          awlen_q, awlen_d, b1_len_q, b1_len_d;
   logic [7:0]          beat_q, beat_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic                b1_pend_q, b1_pend_d;
   logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic [1:0]          resp_q, resp_d;

   logic [ADDR_W-1:0]   c_addr;
   logic [PW-1:0]       c_page;
   logic [8:0]          c_total, c_avail;
   logic                in_burst, aw_fire, w_fire, last_beat;
   logic                unused_ok;

   assign unused_ok = ^{cmd_addr[3:0], bid};

   assign in_burst  = state_q == S_BURST;
   assign last_beat = beat_q == awlen_q;
   assign cmd_ready = state_q == S_IDLE;
   assign awvalid   = in_burst && !aw_done_q;
   assign wvalid    = in_burst && !w_done_q && wd_valid;
   assign wd_ready  = in_burst && !w_done_q && wready;
   assign wlast     = in_burst && last_beat;
   assign wdata     = wd_data;
   assign wstrb     = wd_strb;
   assign bready    = state_q == S_BRESP;
   assign rsp_valid = state_q == S_RSP;
   assign rsp_id    = id_q;
   assign rsp_resp  = resp_q;
   assign awaddr    = awaddr_q;
   assign awlen     = awlen_q;
   assign awid      = id_q;
   assign awsize    = 3'b100;
   assign awburst   = 2'b01;
   assign awcache   = AWCACHE_VAL;
   assign awlock    = 1'b0;
   assign awprot    = 3'b000;
   assign awqos     = 4'h0;
   assign awregion  = 4'h0;

   assign aw_fire = awvalid && awready;
   assign w_fire  = wvalid && wready;

   always_comb begin
      c_addr    = {cmd_addr[ADDR_W-1:4], 4'h0};
      c_page    = c_addr[ADDR_W-1:12] + PW'(1);
      c_total   = {1'b0, cmd_len} + 9'd1;
      c_avail   = 9'd256 - {1'b0, c_addr[11:4]};
      state_d   = state_q;
      awaddr_d  = awaddr_q;
      awlen_d   = awlen_q;
      b1_addr_d = b1_addr_q;
      b1_len_d  = b1_len_q;
      b1_pend_d = b1_pend_q;
      beat_d    = beat_q;
      id_d      = id_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      resp_d    = resp_q;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               awaddr_d  = c_addr;
               id_d      = cmd_id;
               resp_d    = 2'b00;
               beat_d    = 8'd0;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               b1_addr_d = {c_page, 12'h000};
               b1_len_d  = 8'(c_total - c_avail - 9'd1);
               // A burst may not cross 4 KB; the remainder becomes burst 1
               if (c_total > c_avail) begin
                  awlen_d   = 8'(c_avail - 9'd1);
                  b1_pend_d = 1'b1;
               end else begin
                  awlen_d   = cmd_len;
                  b1_pend_d = 1'b0;
               end
               state_d = S_BURST;
            end
         end
         S_BURST: begin
            if (aw_fire) aw_done_d = 1'b1;
            if (w_fire) begin
               if (last_beat) w_done_d = 1'b1;
               else beat_d = beat_q + 8'd1;
            end
            if ((aw_done_q || aw_fire) &&
                (w_done_q || (w_fire && last_beat))) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               beat_d    = 8'd0;
               state_d   = S_BRESP;
            end
         end
         S_BRESP: begin
            if (bvalid) begin
               if (resp_q == 2'b00) resp_d = bresp;
               if (b1_pend_q) begin
                  awaddr_d  = b1_addr_q;
                  awlen_d   = b1_len_q;
                  b1_pend_d = 1'b0;
                  state_d   = S_BURST;
               end else begin
                  state_d = S_RSP;
               end
            end
         end
         S_RSP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= S_IDLE;
         awaddr_q  <= '0;
         awlen_q   <= '0;
         b1_addr_q <= '0;
         b1_len_q  <= '0;
         b1_pend_q <= 1'b0;
         beat_q    <= '0;
         id_q      <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         resp_q    <= '0;
      end else begin
         state_q   <= state_d;
         awaddr_q  <= awaddr_d;
         awlen_q   <= awlen_d;
         b1_addr_q <= b1_addr_d;
         b1_len_q  <= b1_len_d;
         b1_pend_q <= b1_pend_d;
         beat_q    <= beat_d;
         id_q      <= id_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         resp_q    <= resp_d;
      end
   end

`ifdef AXI4_WR_BURST_WDOG_EN
   logic [9:0] wd_cnt_q, wd_cnt_d;
   logic       wdog_err_q, wdog_err_d;

   assign wdog_err = wdog_err_q;

   always_comb begin
      wd_cnt_d   = 10'd0;
      wdog_err_d = wdog_err_q || (wd_cnt_q == 10'h3FF);
      if (state_q == S_BRESP)
         wd_cnt_d = (wd_cnt_q == 10'h3FF) ? wd_cnt_q : wd_cnt_q + 10'd1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wd_cnt_q   <= '0;
         wdog_err_q <= 1'b0;
      end else begin
         wd_cnt_q   <= wd_cnt_d;
         wdog_err_q <= wdog_err_d;
      end
   end
`endif

endmodule

// File: tb/tb_axi4_wr_burst_master.sv
// Directed bench for axi4_wr_burst_master with a small AXI slave and payload source.
// Watchdog checks compile in when AXI4_WR_BURST_WDOG_EN is defined.
module tb_axi4_wr_burst_master;

   logic         CLK = 1'b0;
   logic         RST;
   logic         cmd_valid, cmd_ready;
   logic [13:0]  cmd_addr;
   logic [7:0]   cmd_len;
   logic [1:0]   cmd_id;
   logic         wd_valid, wd_ready;
   logic [127:0] wd_data;
   logic [15:0]  wd_strb;
   logic         rsp_valid, rsp_ready;
   logic [1:0]   rsp_id, rsp_resp;
   logic [13:0]  awaddr;
   logic [7:0]   awlen;
   logic [1:0]   awid;
   logic [2:0]   awsize;
   logic [1:0]   awburst;
   logic [3:0]   awcache;
   logic         awlock;
   logic [2:0]   awprot;
   logic [3:0]   awqos, awregion;
   logic         awvalid, awready;
   logic [127:0] wdata;
   logic [15:0]  wstrb;
   logic         wlast, wvalid, wready;
   logic [1:0]   bid, bresp;
   logic         bvalid, bready;
`ifdef AXI4_WR_BURST_WDOG_EN
   logic         wdog_err;
`endif

   axi4_wr_burst_master dut (
      .CLK(CLK), .RST(RST),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
      .wd_valid(wd_valid), .wd_ready(wd_ready),
      .wd_data(wd_data), .wd_strb(wd_strb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_resp(rsp_resp),
      .awaddr(awaddr), .awlen(awlen), .awid(awid),
      .awsize(awsize), .awburst(awburst), .awcache(awcache),
      .awlock(awlock), .awprot(awprot), .awqos(awqos),
      .awregion(awregion),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid),
`ifdef AXI4_WR_BURST_WDOG_EN
      .wdog_err(wdog_err),
`endif
      .bready(bready)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   int src_n, src_idx, aw_delay, aw_wait, b_delay, b_wait;
   int aw_cnt, b_cnt, last_cnt, stab_err, cyc;
   bit wr_toggle;
   bit hold_v;
   logic [23:0] hold_f;
   logic [7:0]  dtag = 8'h00;
   logic [1:0]  bresp_tab [4];

   logic [13:0]  aw_addr_log [$];
   logic [7:0]   aw_len_log [$];
   logic [1:0]   aw_id_log [$];
   logic [127:0] w_data_log [$];
   logic [15:0]  w_strb_log [$];
   bit           w_last_log [$];

   function automatic logic [127:0] bdata(input int i);
      return {dtag, i[23:0], 32'hC0DE0000 ^ i, i * 7, ~i};
   endfunction

   function automatic logic [15:0] bstrb(input int i);
      int v;
      v = (i * 13) ^ 32'h0000A5C3;
      return v[15:0];
   endfunction

   task automatic chk(input string nm, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", nm, obs, exp);
      end
   endtask

   task automatic clear_slave();
      aw_addr_log.delete();
      aw_len_log.delete();
      aw_id_log.delete();
      w_data_log.delete();
      w_strb_log.delete();
      w_last_log.delete();
      src_n = 0; src_idx = 0;
      aw_wait = 0; b_wait = 0;
      aw_cnt = 0; b_cnt = 0; last_cnt = 0;
      stab_err = 0; hold_v = 1'b0;
   endtask

   // Slave and payload source: drive just after posedge, sample at negedge
   initial begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      bresp = 2'b00; bid = 2'b00;
      wd_valid = 1'b0; wd_data = '0; wd_strb = '0;
      cyc = 0; aw_delay = 0; b_delay = 0; wr_toggle = 1'b0;
      for (int i = 0; i < 4; i++) bresp_tab[i] = 2'b00;
      clear_slave();
      forever begin
         @(posedge CLK); #1;
         cyc++;
         wd_valid = src_idx < src_n;
         wd_data  = bdata(src_idx);
         wd_strb  = bstrb(src_idx);
         wready   = wr_toggle ? cyc[0] : 1'b1;
         awready  = awvalid && (aw_wait >= aw_delay);
         bvalid   = (last_cnt > b_cnt) && (aw_cnt > b_cnt) &&
                    (b_wait >= b_delay);
         bresp    = bresp_tab[b_cnt[1:0]];
         bid      = awid;
         @(negedge CLK);
         if (wd_valid && wd_ready) src_idx++;
         if (wvalid && wready) begin
            w_data_log.push_back(wdata);
            w_strb_log.push_back(wstrb);
            w_last_log.push_back(wlast);
            if (wlast) last_cnt++;
         end
         if (hold_v && awvalid && ({awaddr, awlen, awid} !== hold_f))
            stab_err++;
         hold_v = awvalid && !awready;
         hold_f = {awaddr, awlen, awid};
         if (awvalid && awready) begin
            aw_addr_log.push_back(awaddr);
            aw_len_log.push_back(awlen);
            aw_id_log.push_back(awid);
            aw_cnt++;
            aw_wait = 0;
         end else if (awvalid) begin
            aw_wait++;
         end
         if (bvalid && bready) begin
            b_cnt++;
            b_wait = 0;
         end else if (last_cnt > b_cnt && aw_cnt > b_cnt) begin
            b_wait++;
         end
      end
   end

   task automatic run_cmd(input logic [13:0] a, input logic [7:0] l,
                          input logic [1:0] id, input logic [1:0] eresp,
                          input int naw, input int nb0,
                          input logic [13:0] a0, input logic [7:0] l0,
                          input logic [13:0] a1, input logic [7:0] l1);
      int n, bad, total;
      bit el;
      total = int'(l) + 1;
      @(negedge CLK); #1;
      clear_slave();
      dtag = dtag + 8'd1;
      src_n = total + 2;
      cmd_addr = a; cmd_len = l; cmd_id = id;
      cmd_valid = 1'b1;
      @(negedge CLK);
      chk("aw_1cyc", 32'(awvalid), 1);
      chk("cmd_ready_busy", 32'(cmd_ready), 0);
      #1 cmd_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 3000) begin
         @(negedge CLK);
         n++;
      end
      chk("rsp_timeout", 32'(rsp_valid), 1);
      chk("rsp_id", 32'(rsp_id), 32'(id));
      chk("rsp_resp", 32'(rsp_resp), 32'(eresp));
      @(negedge CLK);
      chk("rsp_hold_resp", 32'(rsp_resp), 32'(eresp));
      #1 rsp_ready = 1'b1;
      @(negedge CLK);
      chk("rsp_done", 32'(rsp_valid), 0);
      chk("idle_cmd_ready", 32'(cmd_ready), 1);
      #1 rsp_ready = 1'b0;
      chk("aw_count", aw_cnt, naw);
      chk("aw0_addr", 32'(aw_addr_log[0]), 32'(a0));
      chk("aw0_len", 32'(aw_len_log[0]), 32'(l0));
      chk("aw0_id", 32'(aw_id_log[0]), 32'(id));
      if (naw == 2) begin
         chk("aw1_addr", 32'(aw_addr_log[1]), 32'(a1));
         chk("aw1_len", 32'(aw_len_log[1]), 32'(l1));
      end
      chk("w_beats", w_data_log.size(), total);
      chk("src_consumed", src_idx, total);
      chk("b_count", b_cnt, naw);
      chk("aw_stable", stab_err, 0);
      bad = 0;
      for (int i = 0; i < total; i++) begin
         el = (i == nb0 - 1) || (i == total - 1);
         if (w_data_log[i] !== bdata(i)) bad++;
         if (w_strb_log[i] !== bstrb(i)) bad++;
         if (w_last_log[i] !== el) bad++;
      end
      chk("w_stream", bad, 0);
   endtask

   initial begin
      int n;
      RST = 1'b1;
      cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_cmd_ready", 32'(cmd_ready), 1);
      chk("rst_valids",
          32'({awvalid, wvalid, bready, rsp_valid, wd_ready}), 0);
      chk("rst_aw_fields", 32'({awaddr, awlen, awid}), 0);
      chk("rst_rsp", 32'({rsp_id, rsp_resp}), 0);
      chk("const_size_burst", 32'({awsize, awburst}), 32'h11);
      chk("const_cache", 32'(awcache), 3);
      chk("const_zero", 32'({awlock, awprot, awqos, awregion}), 0);
`ifdef AXI4_WR_BURST_WDOG_EN
      chk("rst_wdog", 32'(wdog_err), 0);
`endif
      #1 RST = 1'b0;

      run_cmd(14'h0100, 8'd0, 2'd1, 2'b00, 1, 1,
              14'h0100, 8'd0, 14'h0000, 8'd0);
      run_cmd(14'h1000, 8'd255, 2'd2, 2'b00, 1, 256,
              14'h1000, 8'd255, 14'h0000, 8'd0);
      bresp_tab[1] = 2'b11;
      run_cmd(14'h0FE0, 8'd3, 2'd3, 2'b11, 2, 2,
              14'h0FE0, 8'd1, 14'h1000, 8'd1);
      bresp_tab[0] = 2'b10;
      bresp_tab[1] = 2'b00;
      run_cmd(14'h3FF0, 8'd1, 2'd0, 2'b10, 2, 1,
              14'h3FF0, 8'd0, 14'h0000, 8'd0);
      bresp_tab[0] = 2'b00;
      aw_delay = 5;
      wr_toggle = 1'b1;
      run_cmd(14'h020F, 8'd5, 2'd2, 2'b00, 1, 6,
              14'h0200, 8'd5, 14'h0000, 8'd0);

      // Reset in the middle of a long burst
      @(negedge CLK); #1;
      clear_slave();
      src_n = 300;
      cmd_addr = 14'h2000; cmd_len = 8'd255; cmd_id = 2'd1;
      cmd_valid = 1'b1;
      @(negedge CLK); #1 cmd_valid = 1'b0;
      repeat (10) @(negedge CLK);
      chk("mid_burst_w", 32'(wvalid || awvalid), 1);
      @(posedge CLK); #2 RST = 1'b1;
      #1;
      chk("async_valids",
          32'({awvalid, wvalid, bready, rsp_valid, wd_ready}), 0);
      chk("async_idle", 32'(cmd_ready), 1);
      chk("async_awaddr", 32'(awaddr), 0);
      @(negedge CLK); #1;
      clear_slave();
      RST = 1'b0;
      n = 0;
      repeat (20) begin
         @(negedge CLK);
         if (rsp_valid || awvalid || wvalid) n++;
      end
      chk("no_partial_rsp", n, 0);
      aw_delay = 0;
      wr_toggle = 1'b0;
      run_cmd(14'h0340, 8'd2, 2'd3, 2'b00, 1, 3,
              14'h0340, 8'd2, 14'h0000, 8'd0);

`ifdef AXI4_WR_BURST_WDOG_EN
      b_delay = 1100;
      run_cmd(14'h0300, 8'd0, 2'd1, 2'b00, 1, 1,
              14'h0300, 8'd0, 14'h0000, 8'd0);
      chk("wdog_sticky", 32'(wdog_err), 1);
      b_delay = 0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axi4_wr_burst_master.md
Name: axi4_wr_burst_master

Overview:
- Command-driven AXI4 write master that feeds the 14-bit-address / 128-bit-data AXI4 slave endpoint on its AW, W and B channels.
- Accepts one write command (start address, beat count, ID) plus a streamed payload.
- Splits any command that crosses a 4 KB boundary into two legal INCR bursts.
- Returns one merged completion per command.
- One command in flight at a time; the slave's read channels are not driven by this block.

Parameters:
- ADDR_W, 14, byte address width of the AXI side.
- DATA_W, 128, data width; strobe width is DATA_W/8.
- ID_W, 2, AXI ID width.
- AWCACHE_VAL, 4'b0011, constant driven on awcache.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- cmd_valid/cmd_ready  in/out  1  command handshake.
- cmd_addr  in  ADDR_W  start byte address; bits [3:0] ignored (forced 0).
- cmd_len  in  8  beats minus 1 (1..256 beats).
- cmd_id  in  ID_W  ID used on awid.
- wd_valid/wd_ready  in/out  1  payload handshake.
- wd_data  in  DATA_W  payload beat.
- wd_strb  in  DATA_W/8  payload byte enables.
- rsp_valid/rsp_ready  out/in  1  completion handshake.
- rsp_id  out  ID_W  ID of the completed command.
- rsp_resp  out  2  merged response.
- awaddr  out  ADDR_W  AXI burst address.
- awlen  out  8  AXI burst length.
- awid  out  ID_W  AXI ID.
- awsize  out  3  constant 3'b100.
- awburst  out  2  constant 2'b01 (INCR).
- awcache  out  4  constant AWCACHE_VAL.
- awlock, awprot, awqos, awregion  out  1/3/4/4  constant 0.
- awvalid/awready  out/in  1  AW handshake.
- wdata/wstrb  out  DATA_W, DATA_W/8  W channel data.
- wlast  out  1  last beat of the current AXI burst.
- wvalid/wready  out/in  1  W handshake.
- bid, bresp  in  ID_W, 2  B channel.
- bvalid/bready  in/out  1  B handshake.

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - cmd_ready=1; awvalid, wvalid, bready, rsp_valid, wd_ready = 0.
  - awaddr, awlen, awid, rsp_id, rsp_resp = 0.
  - Reset mid-burst abandons the transfer immediately; no partial completion is emitted.
- States: IDLE -> BURST -> BRESP -> (BURST | RSP) -> IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch addr (low 4 bits zeroed), total = cmd_len+1, and id.
  - Compute avail = 256 - addr[11:4].
  - If total > avail:
    - burst0 len = avail-1.
    - burst1 addr = {addr[13:12]+1, 12'h000}, truncated to ADDR_W, so 0x3xxx wraps to 0x0000.
    - burst1 len = total-avail-1.
  - Else a single burst is issued.
  - Next cycle: BURST.
- BURST:
  - awvalid held with stable awaddr/awlen/awid until awready.
  - W runs concurrently: wvalid=wd_valid, wd_ready=wready, wdata/wstrb pass through combinationally.
  - The W stream may lead or lag AW.
  - wlast=1 on the beat where the beat counter equals current awlen.
  - Go to BRESP when both the AW handshake and the wlast beat have completed, in either order or the same cycle.
- BRESP:
  - bready=1.
  - On bvalid, merge: first non-OKAY bresp is kept; otherwise OKAY. bid is not checked.
  - If a second burst is pending, reload AW fields and return to BURST; else go to RSP.
- RSP:
  - rsp_valid=1; rsp_id/rsp_resp stable until rsp_ready.
  - Then IDLE, with cmd_ready=1 on the next cycle, so there is no back-to-back acceptance in the same cycle.
- Throughput: one beat per cycle when wready and wd_valid are both high.
  - Command acceptance to first awvalid: 1 cycle.
- wd_ready=0 outside BURST; payload beyond the command's beat count is never consumed.

Optional Feature:
- Macro: AXI4_WR_BURST_WDOG_EN.
- Defined:
  - Adds output wdog_err (1 bit, reset 0).
  - A 10-bit counter runs while in BRESP and clears on leaving it.
  - Reaching 1023 sets wdog_err; it stays set until RST.
  - The FSM keeps waiting for bvalid; behaviour is otherwise unchanged.
- Undefined: no port, no counter.

Test Plan:
- Single beat: cmd addr=0x0100, len=0, id=1; slave bresp=OKAY.
  - Expect one AW (awaddr=0x0100, awlen=0, awsize=4, awburst=1), one W with wlast=1.
  - Then rsp_id=1, rsp_resp=0.
- Max burst, aligned: addr=0x1000, len=255.
  - Expect one AW with awlen=255 and 256 W beats; wlast only on beat 256.
- 4 KB split: addr=0x0FE0, len=3.
  - Expect AW0 0x0FE0/len1 (wlast on beat 2), then AW1 0x1000/len1 (wlast on beat 4).
  - Expect a single rsp.
- Wrap and error merge: addr=0x3FF0, len=1.
  - Expect AW 0x3FF0/len0, then AW 0x0000/len0.
  - Burst0 bresp=SLVERR, burst1 OKAY -> rsp_resp=2'b10.
- Backpressure/order: W data presented before awready, awready delayed 5 cycles, wready toggling.
  - No beat lost or duplicated; AW fields stable while awvalid=1.
  - RST asserted mid-burst -> all valids 0 asynchronously.
- With AXI4_WR_BURST_WDOG_EN: bvalid withheld 1100 cycles.
  - wdog_err rises after 1023 BRESP cycles, stays 1 after bvalid and the rsp complete.
